// File: rtl/fp_pkg.sv
// Shared fixed-point helpers for the FFT datapath (mult_fp, div_fp, sat_fp).
// Holds the operation state encoding, Q-format width expressions and saturation constants.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } fp_state_e;

  function automatic int calc_iw(input int int_bit, input int frac_bit);
    return 1 + int_bit + frac_bit;
  endfunction

  function automatic int calc_ow(input int int_bit, input int frac_bit);
    return 1 + int_bit + frac_bit;
  endfunction

  // One quotient bit per dividend bit: magnitude plus the extra output fraction.
  function automatic int calc_n(input int iw, input int out_frac_bit);
    return iw + out_frac_bit;
  endfunction

  function automatic logic [63:0] max_pos(input int ow);
    return (64'd1 << (ow - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] most_neg(input int ow);
    return 64'd1 << (ow - 1);
  endfunction

endpackage

// File: rtl/sat_fp.sv
// Applies a sign to an unsigned magnitude and saturates into an OW-bit two's complement word.
// Purely combinational, no handshake; the caller registers the result.
module sat_fp
  import fp_pkg::*;
#(
  parameter int MW = 13,
  parameter int OW = 10
) (
  input  logic [MW-1:0] mag,
  input  logic          neg,
  output logic [OW-1:0] res
);

  localparam int WW = ((MW > OW) ? MW : OW) + 1;
  localparam logic [OW-1:0] MAX_POS  = OW'(max_pos(OW));
  localparam logic [OW-1:0] MOST_NEG = OW'(most_neg(OW));

  logic [WW-1:0] mag_w;
  logic [OW-1:0] mag_t;

  assign mag_w = WW'(mag);
  assign mag_t = OW'(mag);

  // Negative side reaches one step further: 2^(OW-1) itself is representable.
  always_comb begin
    res = mag_t;
    if (!neg) begin
      if (mag_w > WW'(MAX_POS)) res = MAX_POS;
    end else if (mag_w > WW'(MOST_NEG)) begin
      res = MOST_NEG;
    end else begin
      res = OW'(0) - mag_t;
    end
  end

endmodule

// File: rtl/div_fp.sv
// Signed fixed-point divider, restoring magnitude division at one quotient bit per cycle.
// Latency: accept -> out_valid after N+1 edges (2 edges when B is zero); one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module div_fp
  import fp_pkg::*;
#(
  parameter int in_frac_bit  = 5,
  parameter int in_int_bit   = 2,
  parameter int out_frac_bit = 5,
  parameter int out_int_bit  = 4,
  localparam int IW = calc_iw(in_int_bit, in_frac_bit),
  localparam int OW = calc_ow(out_int_bit, out_frac_bit)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] A,
  input  logic [IW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out,
  output logic          div_zero
);

  localparam int N  = calc_n(IW, out_frac_bit);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  fp_state_e     state;
  logic          sign;
  logic [IW-1:0] mag_b;
  logic [N-1:0]  dvd;
  logic [N-1:0]  quot;
  logic [IW:0]   rem;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          dz_wait;

  logic [IW-1:0] mag_a_in;
  logic [IW-1:0] mag_b_in;
  logic [IW+1:0] trial;
  logic          q_bit;
  logic [N-1:0]  sat_mag;
  logic [OW-1:0] sat_res;

  assign in_ready = (state == ST_IDLE);

  // IW-bit unsigned magnitudes so that |-2^(IW-1)| fits.
  assign mag_a_in = A[IW-1] ? (IW'(0) - A) : A;
  assign mag_b_in = B[IW-1] ? (IW'(0) - B) : B;

  // Shift the next dividend bit into the remainder and try subtracting the divisor.
  assign trial = {rem, dvd[N-1]} - (IW + 2)'(mag_b);
  assign q_bit = ~trial[IW+1];

  // A zero divisor never shifts the dividend, so |dvd tells whether A was nonzero.
  assign sat_mag = dz ? {N{|dvd}} : quot;

  sat_fp #(
    .MW (N),
    .OW (OW)
  ) u_sat (
    .mag (sat_mag),
    .neg (sign),
    .res (sat_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sign      <= 1'b0;
      mag_b     <= '0;
      dvd       <= '0;
      quot      <= '0;
      rem       <= '0;
      cnt       <= '0;
      dz        <= 1'b0;
      dz_wait   <= 1'b0;
      out       <= '0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign    <= A[IW-1] ^ B[IW-1];
            mag_b   <= mag_b_in;
            dvd     <= {mag_a_in, {out_frac_bit{1'b0}}};
            quot    <= '0;
            rem     <= '0;
            cnt     <= CW'(N - 1);
            dz      <= (B == '0);
            dz_wait <= (B == '0);
            state   <= (B == '0) ? ST_FIN : ST_CALC;
          end
        end
        ST_CALC: begin
          rem  <= q_bit ? trial[IW:0] : {rem[IW-1:0], dvd[N-1]};
          quot <= {quot[N-2:0], q_bit};
          dvd  <= {dvd[N-2:0], 1'b0};
          if (cnt == '0) state <= ST_FIN;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIN: begin
          // Divide-by-zero spends two cycles here so its result lands at accept+2.
          if (dz_wait) begin
            dz_wait <= 1'b0;
          end else begin
            out       <= sat_res;
            div_zero  <= dz;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fp.sv
// Directed bench for div_fp at default Q-formats (Q2.5 in, Q4.5 out).
module tb_div_fp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

  div_fp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncate-toward-zero quotient in Q4.5, saturated to 10 bits.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
    int ai, bi, ma, mb, q, r;
    logic neg;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      r = (ai > 0) ? 511 : ((ai < 0) ? -512 : 0);
      return {1'b1, 10'(r)};
    end
    ma  = (ai < 0) ? -ai : ai;
    mb  = (bi < 0) ? -bi : bi;
    q   = (ma * 32) / mb;
    neg = (ai < 0) ^ (bi < 0);
    if (!neg) r = (q > 511) ? 511 : q;
    else      r = (q > 512) ? -512 : -q;
    return {1'b0, 10'(r)};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [9:0] exp_out, input logic exp_dz, input int exp_lat,
                        input int hold, input bit toggle, input int gap);
    int n;
    int lat;
    logic [9:0] held;
    logic bad;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    A = a;
    B = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, " accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (toggle) begin
        A = 8'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) begin
      check({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " out"}, 32'(out), 32'(exp_out));
    check({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
    held = out;
    bad  = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1 if (out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    if (hold > 0) check({tag, " hold stable"}, 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] m;
    logic [7:0]  ra, rb;
    logic        spur;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out", 32'(out), 32'd0);
    check("rst div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("one_div_half", 8'h20, 8'h10, 10'h040, 1'b0, 14, 0, 1'b0, 0);
    run_op("one_div_three", 8'h20, 8'h60, 10'h00A, 1'b0, 14, 0, 1'b0, 0);
    run_op("m_one_div_three", 8'hE0, 8'h60, 10'h3F6, 1'b0, 14, 0, 1'b0, 0);
    run_op("sat_pos", 8'h7F, 8'h01, 10'h1FF, 1'b0, 14, 0, 1'b0, 0);
    run_op("sat_neg", 8'h80, 8'h01, 10'h200, 1'b0, 14, 0, 1'b0, 0);
    run_op("neg_neg", 8'hE0, 8'hF0, 10'h040, 1'b0, 14, 0, 1'b0, 1);
    run_op("min_div_min", 8'h80, 8'h80, 10'h020, 1'b0, 14, 0, 1'b0, 0);
    run_op("min_div_max", 8'h80, 8'h7F, 10'h3E0, 1'b0, 14, 0, 1'b0, 0);
    run_op("dz_pos", 8'h20, 8'h00, 10'h1FF, 1'b1, 2, 0, 1'b0, 0);
    run_op("dz_neg", 8'hE0, 8'h00, 10'h200, 1'b1, 2, 0, 1'b0, 0);
    run_op("dz_zero", 8'h00, 8'h00, 10'h000, 1'b1, 2, 0, 1'b0, 0);
    run_op("backpressure", 8'h20, 8'h10, 10'h040, 1'b0, 14, 5, 1'b0, 0);
    run_op("toggle_calc", 8'h20, 8'h60, 10'h00A, 1'b0, 14, 0, 1'b1, 0);

    // Reset six edges into an operation: nothing may come out afterwards.
    @(negedge clk);
    A = 8'h20;
    B = 8'h10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out", 32'(out), 32'd0);
    check("midrst div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0) spur = 1'b1;
    end
    check("midrst no spurious out_valid", 32'(spur), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = (i % 9 == 0) ? 8'h00 : 8'($urandom);
      m  = model(ra, rb);
      run_op($sformatf("sweep%0d", i), ra, rb, m[9:0], m[10], (rb == 8'h00) ? 2 : 14,
             int'($urandom_range(0, 2)), 1'b0, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
